// File: rtl/cache_controller_pkg.sv
// Shared types and constants for the 2-way set-associative L1 cache controller.
package cache_controller_pkg;

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_state_t;

  localparam int CACHE_WAYS = 2;

endpackage

// File: rtl/cache_controller_if.sv
// Controller-side bundle: CPU request/response, pmem handshake, datapath status and array strobes.
interface cache_controller_if;
  logic mem_read, mem_write, mem_resp;
  logic pmem_read, pmem_write, pmem_resp;
  logic hit, comp2, LRU_out, dirty_LRU;
  logic LRU_write, LRU_in;
  logic v1_write, v1_in, d1_write, d1_in, t1_write, data1_write;
  logic v2_write, v2_in, d2_write, d2_in, t2_write, data2_write;
  logic allocate_sel;

  modport master (
    input  mem_read, mem_write, pmem_resp, hit, comp2, LRU_out, dirty_LRU,
    output mem_resp, pmem_read, pmem_write, LRU_write, LRU_in,
    output v1_write, v1_in, d1_write, d1_in, t1_write, data1_write,
    output v2_write, v2_in, d2_write, d2_in, t2_write, data2_write,
    output allocate_sel
  );

  modport slave (
    output mem_read, mem_write, pmem_resp, hit, comp2, LRU_out, dirty_LRU,
    input  mem_resp, pmem_read, pmem_write, LRU_write, LRU_in,
    input  v1_write, v1_in, d1_write, d1_in, t1_write, data1_write,
    input  v2_write, v2_in, d2_write, d2_in, t2_write, data2_write,
    input  allocate_sel
  );
endinterface

// File: rtl/cache_controller_perf_counter.sv
// Wrapping enable-increment event counter with synchronous active-high reset.
module cache_perf_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)     count <= '0;
    else if (en) count <= count + 1'b1;
  end

endmodule

// File: rtl/cache_controller.sv
// Write-back / write-allocate L1 controller: decodes datapath status into array
// strobes and pmem requests, and keeps hit/miss performance counters.
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  cache_controller_if.master bus,
  output logic [CNT_W-1:0]   hit_count,
  output logic [CNT_W-1:0]   miss_count
);

  localparam logic [1:0] ST_CHECK = CHECK;
  localparam logic [1:0] ST_WB    = WRITEBACK;
  localparam logic [1:0] ST_ALLOC = ALLOCATE;

  logic [1:0] state_p0, state_nxt;
  logic       first_chk_p0;
  logic       req, hit_inc, miss_inc;

  // A simultaneous read and write is serviced as a write.
  assign req = bus.mem_read | bus.mem_write;

  always_comb begin
    state_nxt        = state_p0;
    hit_inc          = 1'b0;
    miss_inc         = 1'b0;
    bus.mem_resp     = 1'b0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.LRU_write    = 1'b0;
    bus.LRU_in       = 1'b0;
    bus.v1_write     = 1'b0;
    bus.v1_in        = 1'b0;
    bus.d1_write     = 1'b0;
    bus.d1_in        = 1'b0;
    bus.t1_write     = 1'b0;
    bus.data1_write  = 1'b0;
    bus.v2_write     = 1'b0;
    bus.v2_in        = 1'b0;
    bus.d2_write     = 1'b0;
    bus.d2_in        = 1'b0;
    bus.t2_write     = 1'b0;
    bus.data2_write  = 1'b0;
    bus.allocate_sel = 1'b0;
    if (!reset) begin
      case (state_p0)
        ST_CHECK: begin
          if (req && bus.hit) begin
            bus.mem_resp  = 1'b1;
            bus.LRU_write = 1'b1;
            bus.LRU_in    = ~bus.comp2;
            hit_inc       = first_chk_p0;
            if (bus.mem_write) begin
              if (bus.comp2) begin
                bus.data2_write = 1'b1;
                bus.d2_write    = 1'b1;
                bus.d2_in       = 1'b1;
              end else begin
                bus.data1_write = 1'b1;
                bus.d1_write    = 1'b1;
                bus.d1_in       = 1'b1;
              end
            end
          end else if (req) begin
            miss_inc  = 1'b1;
            state_nxt = bus.dirty_LRU ? ST_WB : ST_ALLOC;
          end
        end
        ST_WB: begin
          bus.pmem_write = 1'b1;
          if (bus.pmem_resp) begin
            // Clearing the victim's dirty bit flips the pmem address mux back to the CPU address.
            if (bus.LRU_out) bus.d2_write = 1'b1;
            else             bus.d1_write = 1'b1;
            state_nxt = ST_ALLOC;
          end
        end
        ST_ALLOC: begin
          bus.pmem_read = 1'b1;
          if (bus.pmem_resp) begin
            bus.allocate_sel = 1'b1;
            if (bus.LRU_out) begin
              bus.data2_write = 1'b1;
              bus.t2_write    = 1'b1;
              bus.v2_write    = 1'b1;
              bus.v2_in       = 1'b1;
              bus.d2_write    = 1'b1;
            end else begin
              bus.data1_write = 1'b1;
              bus.t1_write    = 1'b1;
              bus.v1_write    = 1'b1;
              bus.v1_in       = 1'b1;
              bus.d1_write    = 1'b1;
            end
            state_nxt = ST_CHECK;
          end
        end
        default: state_nxt = ST_CHECK;
      endcase
    end
  end

  // State and first-check flag: a hit after a fill is not counted; an idle CHECK re-arms the flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0     <= ST_CHECK;
      first_chk_p0 <= 1'b1;
    end else begin
      state_p0 <= state_nxt;
      if (state_p0 == ST_CHECK) first_chk_p0 <= !(req && !bus.hit);
    end
  end

  cache_perf_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (reset),
    .en    (hit_inc),
    .count (hit_count)
  );

  cache_perf_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (reset),
    .en    (miss_inc),
    .count (miss_count)
  );

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: per-cycle expected strobe vectors go through a
// scoreboard queue; counters are checked against bench-maintained expected values.
module tb_cache_controller;
  localparam int CNT_W = 4;

  localparam logic [17:0] RESP = 18'd1 << 0;
  localparam logic [17:0] PRD  = 18'd1 << 1;
  localparam logic [17:0] PWR  = 18'd1 << 2;
  localparam logic [17:0] LRUW = 18'd1 << 3;
  localparam logic [17:0] LRUI = 18'd1 << 4;
  localparam logic [17:0] V1W  = 18'd1 << 5;
  localparam logic [17:0] V1I  = 18'd1 << 6;
  localparam logic [17:0] D1W  = 18'd1 << 7;
  localparam logic [17:0] D1I  = 18'd1 << 8;
  localparam logic [17:0] T1W  = 18'd1 << 9;
  localparam logic [17:0] DA1W = 18'd1 << 10;
  localparam logic [17:0] V2W  = 18'd1 << 11;
  localparam logic [17:0] V2I  = 18'd1 << 12;
  localparam logic [17:0] D2W  = 18'd1 << 13;
  localparam logic [17:0] D2I  = 18'd1 << 14;
  localparam logic [17:0] T2W  = 18'd1 << 15;
  localparam logic [17:0] DA2W = 18'd1 << 16;
  localparam logic [17:0] ASEL = 18'd1 << 17;

  localparam logic [17:0] FILL1 = PRD | ASEL | DA1W | T1W | V1W | V1I | D1W;
  localparam logic [17:0] FILL2 = PRD | ASEL | DA2W | T2W | V2W | V2I | D2W;

  logic             clk = 1'b0;
  logic             reset;
  logic [CNT_W-1:0] hit_count, miss_count;
  logic [17:0]      obs;
  logic [17:0]      sb_q[$];
  int               n_chk = 0;
  int               n_fail = 0;
  int               exp_hit = 0;
  int               exp_miss = 0;
  int               n_resp = 0;

  cache_controller_if bus();

  cache_controller #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  assign obs = {bus.allocate_sel, bus.data2_write, bus.t2_write, bus.d2_in, bus.d2_write,
                bus.v2_in, bus.v2_write, bus.data1_write, bus.t1_write, bus.d1_in,
                bus.d1_write, bus.v1_in, bus.v1_write, bus.LRU_in, bus.LRU_write,
                bus.pmem_write, bus.pmem_read, bus.mem_resp};

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // One clock of stimulus: drive after the edge, compare popped expectation on the falling edge.
  task automatic step(input string tag, input logic rd, input logic wr, input logic h,
                      input logic c2, input logic lo, input logic dl, input logic pr,
                      input logic rs, input logic [17:0] e);
    logic [17:0] want;
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.hit       = h;
    bus.comp2     = c2;
    bus.LRU_out   = lo;
    bus.dirty_LRU = dl;
    bus.pmem_resp = pr;
    reset         = rs;
    sb_q.push_back(e);
    @(negedge clk);
    want = sb_q.pop_front();
    chk(tag, {14'd0, obs}, {14'd0, want});
    if (obs[0]) n_resp++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_hit_count"},  {28'd0, hit_count},  exp_hit % (1 << CNT_W));
    chk({tag, "_miss_count"}, {28'd0, miss_count}, exp_miss % (1 << CNT_W));
  endtask

  initial begin
    bus.mem_read = 0; bus.mem_write = 0; bus.hit = 0; bus.comp2 = 0;
    bus.LRU_out = 0; bus.dirty_LRU = 0; bus.pmem_resp = 0; reset = 1;
    @(posedge clk); #1;
    // Outputs must stay quiet under reset even with a hitting request present.
    step("reset_quiet", 1, 0, 1, 1, 0, 0, 0, 1, '0);
    chk_cnt("reset");

    step("read_hit_way2", 1, 0, 1, 1, 0, 0, 0, 0, RESP | LRUW);
    exp_hit++; chk_cnt("read_hit");
    step("write_hit_way1", 0, 1, 1, 0, 0, 0, 0, 0, RESP | LRUW | LRUI | DA1W | D1W | D1I);
    exp_hit++; chk_cnt("write_hit");
    step("rw_hit_as_write", 1, 1, 1, 1, 0, 0, 0, 0, RESP | LRUW | DA2W | D2W | D2I);
    exp_hit++;
    step("idle", 0, 0, 0, 0, 0, 0, 0, 0, '0);
    step("pmem_resp_in_check", 0, 0, 0, 0, 0, 0, 1, 0, '0);
    chk_cnt("idle");

    // Clean read miss into way 2, fill arrives on the fifth ALLOCATE cycle.
    n_resp = 0;
    step("clean_miss_check", 1, 0, 0, 0, 1, 0, 0, 0, '0);
    exp_miss++;
    for (int i = 0; i < 4; i++) step("clean_alloc_wait", 1, 0, 0, 0, 1, 0, 0, 0, PRD);
    step("clean_alloc_fill", 1, 0, 0, 0, 1, 0, 1, 0, FILL2);
    step("clean_recheck_hit", 1, 0, 1, 1, 1, 0, 0, 0, RESP | LRUW);
    step("clean_done_idle", 0, 0, 0, 0, 0, 0, 0, 0, '0);
    chk("clean_resp_once", n_resp, 1);
    chk_cnt("clean_miss");

    // Dirty write miss on way 1: writeback, fill, then merge on re-check.
    n_resp = 0;
    step("dirty_miss_check", 0, 1, 0, 0, 0, 1, 0, 0, '0);
    exp_miss++;
    step("wb_wait0", 0, 1, 0, 0, 0, 1, 0, 0, PWR);
    step("wb_wait1", 0, 1, 0, 0, 0, 1, 0, 0, PWR);
    step("wb_done", 0, 1, 0, 0, 0, 1, 1, 0, PWR | D1W);
    step("dirty_alloc_wait0", 0, 1, 0, 0, 0, 0, 0, 0, PRD);
    step("dirty_alloc_wait1", 0, 1, 0, 0, 0, 0, 0, 0, PRD);
    step("dirty_alloc_fill", 0, 1, 0, 0, 0, 0, 1, 0, FILL1);
    step("dirty_recheck_hit", 0, 1, 1, 0, 1, 0, 0, 0, RESP | LRUW | LRUI | DA1W | D1W | D1I);
    step("dirty_done_idle", 0, 0, 0, 0, 0, 0, 0, 0, '0);
    chk("dirty_resp_once", n_resp, 1);
    chk_cnt("dirty_miss");

    // Request withdrawn during ALLOCATE: line still installed, no response.
    n_resp = 0;
    step("drop_miss_check", 1, 0, 0, 0, 0, 0, 0, 0, '0);
    exp_miss++;
    step("drop_alloc_req", 1, 0, 0, 0, 0, 0, 0, 0, PRD);
    step("drop_alloc_noreq", 0, 0, 0, 0, 0, 0, 0, 0, PRD);
    step("drop_alloc_fill", 0, 0, 0, 0, 0, 0, 1, 0, FILL1);
    step("drop_back_check", 0, 0, 0, 0, 0, 0, 0, 0, '0);
    chk("drop_no_resp", n_resp, 0);
    chk_cnt("drop_miss");

    // Reset while filling: no strobes that cycle, back to CHECK, counters cleared.
    step("rst_miss_check", 1, 0, 0, 0, 0, 0, 0, 0, '0);
    step("rst_alloc_wait", 1, 0, 0, 0, 0, 0, 0, 0, PRD);
    step("rst_during_alloc", 1, 0, 0, 0, 0, 0, 1, 1, '0);
    exp_hit = 0; exp_miss = 0;
    step("rst_after_idle", 0, 0, 0, 0, 0, 0, 0, 0, '0);
    chk_cnt("rst_mid_miss");

    // Counter wrap: 17 first-check hits on a 4-bit counter.
    for (int i = 0; i < 17; i++) begin
      step("wrap_hit", 1, 0, 1, 0, 0, 0, 0, 0, RESP | LRUW | LRUI);
      exp_hit++;
    end
    chk_cnt("wrap");
    chk("wrap_value", {28'd0, hit_count}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
